// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory port.
// The arbiter uses the slave view; the environment driving requests and memory uses the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) ();
  logic              start_i;
  logic              req0_i;
  logic              req1_i;
  logic              we0_i;
  logic              we1_i;
  logic [ADDR_W-1:0] addr0_i;
  logic [ADDR_W-1:0] addr1_i;
  logic [DATA_W-1:0] wdata0_i;
  logic [DATA_W-1:0] wdata1_i;
  logic [DATA_W-1:0] rdata0_o;
  logic [DATA_W-1:0] rdata1_o;
  logic              done0_o;
  logic              done1_o;
  logic              stall0_o;
  logic              stall1_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic [CNT_W-1:0]  stall_cnt0_o;

  modport slave (
    input  start_i, req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i,
           wdata0_i, wdata1_i, mem_rdata_i,
    output rdata0_o, rdata1_o, done0_o, done1_o, stall0_o, stall1_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_cnt0_o
  );

  modport master (
    output start_i, req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i,
           wdata0_i, wdata1_i, mem_rdata_i,
    input  rdata0_o, rdata1_o, done0_o, done1_o, stall0_o, stall1_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_cnt0_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter that serialises word accesses onto one fixed-latency
// data-memory port, with per-port stall outputs and a saturating port-0 stall counter.
module dmem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int LAT    = 2,
  parameter int CNT_W  = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(LAT - 1);

  state_t            r_state;
  logic              r_owner;
  logic              r_last;
  logic              r_we;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_done0;
  logic              r_done1;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [CNT_W-1:0]  r_stall_cnt0;

  logic              w_any_req;
  logic              w_pick1;
  logic              w_stall0;
  logic              w_stall1;
  logic              w_gnt_we;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [DATA_W-1:0] w_gnt_wdata;
  logic              w_unused_addr_bits;

  // Port 1 wins when it is the only requester, or on a tie when port 0 was served last.
  assign w_any_req   = bus.req0_i | bus.req1_i;
  assign w_pick1     = bus.req1_i & (~bus.req0_i | ~r_last);
  assign w_gnt_we    = w_pick1 ? bus.we1_i : bus.we0_i;
  assign w_gnt_addr  = w_pick1 ? {bus.addr1_i[ADDR_W-1:2], 2'b00}
                               : {bus.addr0_i[ADDR_W-1:2], 2'b00};
  assign w_gnt_wdata = w_pick1 ? bus.wdata1_i : bus.wdata0_i;

  assign w_stall0 = bus.req0_i & ~r_done0;
  assign w_stall1 = bus.req1_i & ~r_done1;
  assign w_unused_addr_bits = ^{bus.addr0_i[1:0], bus.addr1_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last       <= 1'b1;
      r_we         <= 1'b0;
      r_cnt        <= 4'd0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_stall_cnt0 <= '0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      if (bus.start_i && w_stall0 && (r_stall_cnt0 != '1)) begin
        r_stall_cnt0 <= r_stall_cnt0 + CNT_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start_i && w_any_req) begin
            r_state  <= S_ACCESS;
            r_owner  <= w_pick1;
            r_last   <= w_pick1;
            r_we     <= w_gnt_we;
            r_addr   <= w_gnt_addr;
            r_wdata  <= w_gnt_wdata;
            r_cnt    <= 4'd0;
            r_mem_en <= 1'b1;
            r_mem_we <= w_gnt_we;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LAST_BEAT) begin
            r_state  <= S_RESP;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            // Read data is captured on the final access edge so it is valid alongside done.
            if (!r_we) begin
              if (r_owner) r_rdata1 <= bus.mem_rdata_i;
              else         r_rdata0 <= bus.mem_rdata_i;
            end
            if (r_owner) r_done1 <= 1'b1;
            else         r_done0 <= 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rdata0_o     = r_rdata0;
  assign bus.rdata1_o     = r_rdata1;
  assign bus.done0_o      = r_done0;
  assign bus.done1_o      = r_done1;
  assign bus.stall0_o     = w_stall0;
  assign bus.stall1_o     = w_stall1;
  assign bus.mem_en_o     = r_mem_en;
  assign bus.mem_we_o     = r_mem_we;
  assign bus.mem_addr_o   = r_addr;
  assign bus.mem_wdata_o  = r_wdata;
  assign bus.stall_cnt0_o = r_stall_cnt0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter: a transaction-timing reference model predicts every
// output each cycle; a second instance with a 2-bit stall counter exercises saturation.
module tb_dmem_arbiter;

  localparam int LAT   = 2;
  localparam int NCYC  = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(5), .DATA_W(32), .CNT_W(16)) bus ();
  dmem_arbiter_if #(.ADDR_W(5), .DATA_W(32), .CNT_W(2))  bus2 ();

  dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .LAT(LAT), .CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .LAT(LAT), .CNT_W(2)) dut_sat (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus2)
  );

  assign bus2.start_i  = bus.start_i;
  assign bus2.req0_i   = bus.req0_i;
  assign bus2.req1_i   = bus.req1_i;
  assign bus2.we0_i    = bus.we0_i;
  assign bus2.we1_i    = bus.we1_i;
  assign bus2.addr0_i  = bus.addr0_i;
  assign bus2.addr1_i  = bus.addr1_i;
  assign bus2.wdata0_i = bus.wdata0_i;
  assign bus2.wdata1_i = bus.wdata1_i;

  function automatic logic [31:0] init_word(input int i);
    return 32'h0000_0005 + 32'(i) * 32'h0101_0101;
  endfunction

  // Data_Memory stand-in: combinational read, write on every active write cycle.
  logic [31:0] hw_mem [8];
  logic        mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 8; i++) hw_mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (bus.mem_en_o && bus.mem_we_o) begin
      hw_mem[bus.mem_addr_o[4:2]] <= bus.mem_wdata_o;
    end
  end
  assign bus.mem_rdata_i  = hw_mem[bus.mem_addr_o[4:2]];
  assign bus2.mem_rdata_i = hw_mem[bus.mem_addr_o[4:2]];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Requester state
  logic        act [2];
  logic        done_seen [2];
  logic        p_we [2];
  logic [4:0]  p_addr [2];
  logic [31:0] p_wdata [2];

  // Reference model: one transfer at a time, described by its grant cycle.
  logic        m_ok;
  logic        m_busy;
  int          m_g;
  int          m_owner;
  logic        m_last;
  logic        t_we;
  logic [4:0]  t_addr;
  logic [31:0] t_wdata;
  logic [31:0] m_rdata [2];
  logic [31:0] m_mem [8];
  int          m_cnt;
  int          m_cnt2;

  task automatic new_request(input int p);
    act[p]     = 1'b1;
    p_we[p]    = 1'($urandom_range(0, 1));
    p_addr[p]  = 5'($urandom_range(0, 31));
    p_wdata[p] = $urandom;
  endtask

  initial begin
    logic in_acc, in_resp, grant_ok, pick1;
    logic exp_done [2];

    bus.start_i = 1'b0;
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b0; done_seen[p] = 1'b0; p_we[p] = 1'b0;
      p_addr[p] = '0; p_wdata[p] = '0;
      m_rdata[p] = '0;
    end
    for (int i = 0; i < 8; i++) m_mem[i] = init_word(i);
    m_ok = 1'b0; m_busy = 1'b0; m_g = 0; m_owner = 0; m_last = 1'b1;
    t_we = 1'b0; t_addr = '0; t_wdata = '0; m_cnt = 0; m_cnt2 = 0;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      rst = (c < 3) || ($urandom_range(0, 59) == 0);
      if (c < 3) bus.start_i = 1'b1;
      else if (bus.start_i && $urandom_range(0, 14) == 0) bus.start_i = 1'b0;
      else if (!bus.start_i && $urandom_range(0, 3) == 0) bus.start_i = 1'b1;
      for (int p = 0; p < 2; p++) begin
        if (done_seen[p]) begin
          if ($urandom_range(0, 1) == 1) new_request(p);
          else act[p] = 1'b0;
        end else if (!act[p] && $urandom_range(0, 2) == 0) begin
          new_request(p);
        end
      end
      bus.req0_i = act[0];   bus.req1_i = act[1];
      bus.we0_i = p_we[0];   bus.we1_i = p_we[1];
      bus.addr0_i = p_addr[0]; bus.addr1_i = p_addr[1];
      bus.wdata0_i = p_wdata[0]; bus.wdata1_i = p_wdata[1];

      @(negedge clk);
      in_acc  = m_busy && (c > m_g) && (c <= m_g + LAT);
      in_resp = m_busy && (c == m_g + LAT + 1);
      if (in_resp && !t_we) m_rdata[m_owner] = m_mem[t_addr[4:2]];
      exp_done[0] = in_resp && (m_owner == 0);
      exp_done[1] = in_resp && (m_owner == 1);

      if (m_ok) begin
        check_value("mem_en", 32'(bus.mem_en_o), 32'(in_acc));
        check_value("mem_we", 32'(bus.mem_we_o), 32'(in_acc && t_we));
        if (in_acc) begin
          check_value("mem_addr", 32'(bus.mem_addr_o), 32'({t_addr[4:2], 2'b00}));
          check_value("mem_wdata", bus.mem_wdata_o, t_wdata);
        end
        check_value("done0", 32'(bus.done0_o), 32'(exp_done[0]));
        check_value("done1", 32'(bus.done1_o), 32'(exp_done[1]));
        check_value("rdata0", bus.rdata0_o, m_rdata[0]);
        check_value("rdata1", bus.rdata1_o, m_rdata[1]);
        check_value("stall0", 32'(bus.stall0_o), 32'(act[0] && !exp_done[0]));
        check_value("stall1", 32'(bus.stall1_o), 32'(act[1] && !exp_done[1]));
        check_value("stall_cnt0", 32'(bus.stall_cnt0_o), 32'(m_cnt));
        check_value("stall_cnt0_sat", 32'(bus2.stall_cnt0_o), 32'(m_cnt2));
        if (in_resp)
          $display("txn cycle %0d port %0d %s addr %02h data %08h", c, m_owner,
                   t_we ? "write" : "read ", {t_addr[4:2], 2'b00},
                   t_we ? t_wdata : m_rdata[m_owner]);
      end

      // Memory writes land on every active write cycle, including one cut short by reset.
      if (in_acc && t_we) m_mem[t_addr[4:2]] = t_wdata;
      done_seen[0] = exp_done[0];
      done_seen[1] = exp_done[1];

      if (rst) begin
        m_ok = 1'b1; m_busy = 1'b0; m_last = 1'b1;
        m_rdata[0] = '0; m_rdata[1] = '0;
        m_cnt = 0; m_cnt2 = 0;
      end else begin
        if (bus.start_i && act[0] && !exp_done[0]) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end
        grant_ok = !m_busy;
        if (in_resp) m_busy = 1'b0;
        if (grant_ok && bus.start_i && (act[0] || act[1])) begin
          pick1   = (act[0] && act[1]) ? !m_last : act[1];
          m_owner = pick1 ? 1 : 0;
          m_last  = pick1;
          m_g     = c;
          m_busy  = 1'b1;
          t_we    = p_we[m_owner];
          t_addr  = p_addr[m_owner];
          t_wdata = p_wdata[m_owner];
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
